// File: rtl/raster_shadow_dispatch_pkg.sv
// Shared types for the raster shadow dispatch stage.
// Override `RASTER_DISPATCH_DEPTH to change the default FIFO depth.
`ifndef RASTER_DISPATCH_DEPTH
`define RASTER_DISPATCH_DEPTH 4
`endif

package raster_shadow_dispatch_pkg;

    localparam int DISPATCH_DEPTH = `RASTER_DISPATCH_DEPTH;

    typedef enum logic [1:0] {
        ST_None,
        ST_Opaque,
        ST_Reflective,
        ST_Refractive
    } surface_type_e;

    typedef struct packed {
        surface_type_e surface_type;
        logic [11:0]   x;
        logic [11:0]   y;
        logic [23:0]   color;
        logic [31:0]   shadowing_ray;
    } raster_output_data_t;

    typedef enum logic {
        DS_Idle,
        DS_Hold
    } dispatch_state_e;

    function automatic logic is_hit(raster_output_data_t d);
        return d.surface_type != ST_None;
    endfunction

endpackage

// File: rtl/raster_shadow_dispatch_if.sv
// Raster-result input and shadow/shade output handshakes of the dispatch stage.
interface raster_shadow_dispatch_if;
    import raster_shadow_dispatch_pkg::*;

    logic                valid;
    raster_output_data_t in;
    logic                output_fifo_full;
    logic                shadow_fifo_full;
    logic                shade_fifo_full;
    logic                shadow_valid;
    raster_output_data_t shadow_out;
    logic                shade_valid;
    raster_output_data_t shade_out;

    modport slave (
        input  valid, in, shadow_fifo_full, shade_fifo_full,
        output output_fifo_full, shadow_valid, shadow_out, shade_valid, shade_out
    );

    modport master (
        output valid, in, shadow_fifo_full, shade_fifo_full,
        input  output_fifo_full, shadow_valid, shadow_out, shade_valid, shade_out
    );
endinterface

// File: rtl/raster_shadow_dispatch_fifo.sv
// Result FIFO: storage, pointers, occupancy and the registered almost-full flag.
// Almost-full reserves one slot because the raster samples it a clock before pushing.
module raster_shadow_dispatch_fifo
    import raster_shadow_dispatch_pkg::*;
#(
    parameter  int DEPTH = DISPATCH_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                push,
    input  raster_output_data_t push_data,
    input  logic                pop,
    output raster_output_data_t head,
    output logic [CW-1:0]       count,
    output logic                almost_full
);

    raster_output_data_t mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count_next;
    logic                push_ok;

    // A push into a full FIFO is dropped; the raster is expected never to do this.
    assign push_ok = push && (count < CW'(DEPTH));
    assign head    = mem[rd_ptr];

    // NOTE: count_next is assigned a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + 1'b1;
        else if (!push_ok && pop)
            count_next = count - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            almost_full <= (count_next >= CW'(DEPTH - 1));
        end
    end

    // NOTE: storage is not reset; validity is tracked by count, so contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    overflow_a: assert property (@(posedge clk) disable iff (!resetn)
        !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/raster_shadow_dispatch.sv
// Routes queued raster results: hits to the shadow unit, misses to shade, in order.
// Define RASTER_DISPATCH_PERF_EN to add the dispatch/stall performance counters.
module raster_shadow_dispatch
    import raster_shadow_dispatch_pkg::*;
#(
    parameter int DEPTH = DISPATCH_DEPTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    raster_shadow_dispatch_if.slave bus
`ifdef RASTER_DISPATCH_PERF_EN
    ,
    output logic [31:0]             perf_shadow_cnt,
    output logic [31:0]             perf_bypass_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    dispatch_state_e         state;
    dispatch_state_e         state_next;
    raster_output_data_t     head;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    has_entry;
    logic                    issue_shadow;
    logic                    issue_shade;
    logic                    pop;

    raster_shadow_dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (bus.valid),
        .push_data   (bus.in),
        .pop         (pop),
        .head        (head),
        .count       (fifo_count),
        .almost_full (bus.output_fifo_full)
    );

    assign has_entry = (fifo_count != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= DS_Idle;
        else
            state <= state_next;
    end

    // Hold exists because downstream full flags lag an issue by one clock.
    always_comb begin
        state_next = state;
        case (state)
            DS_Idle: if (issue_shadow || issue_shade) state_next = DS_Hold;
            DS_Hold: state_next = DS_Idle;
            default: state_next = DS_Idle;
        endcase
    end

    // A blocked head stalls the queue; nothing behind it may overtake.
    always_comb begin
        issue_shadow = 1'b0;
        issue_shade  = 1'b0;
        if (state == DS_Idle && has_entry) begin
            if (is_hit(head))
                issue_shadow = !bus.shadow_fifo_full;
            else
                issue_shade  = !bus.shade_fifo_full;
        end
        pop = issue_shadow || issue_shade;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.shadow_valid <= 1'b0;
            bus.shade_valid  <= 1'b0;
        end else begin
            bus.shadow_valid <= issue_shadow;
            bus.shade_valid  <= issue_shade;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_shadow)
            bus.shadow_out <= head;
        if (issue_shade)
            bus.shade_out <= head;
    end

`ifdef RASTER_DISPATCH_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_shadow_cnt <= '0;
            perf_bypass_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (issue_shadow)
                perf_shadow_cnt <= perf_shadow_cnt + 1'b1;
            if (issue_shade)
                perf_bypass_cnt <= perf_bypass_cnt + 1'b1;
            if (state == DS_Idle && has_entry && !pop)
                perf_stall_cnt  <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_raster_shadow_dispatch.sv
// Scoreboard bench for raster_shadow_dispatch: expected entries queue in push order.
module tb_raster_shadow_dispatch;
    import raster_shadow_dispatch_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   shadow_pulses = 0;
    int   shade_pulses  = 0;
    logic prev_any = 1'b0;

    raster_output_data_t exp_q[$];
    int                  pulse_log[$];

    raster_shadow_dispatch_if bus ();

`ifdef RASTER_DISPATCH_PERF_EN
    logic [31:0] perf_shadow_cnt, perf_bypass_cnt, perf_stall_cnt;
`endif

    raster_shadow_dispatch #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
`ifdef RASTER_DISPATCH_PERF_EN
        ,
        .perf_shadow_cnt (perf_shadow_cnt),
        .perf_bypass_cnt (perf_bypass_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic raster_output_data_t mk(surface_type_e st, int x, int y);
        raster_output_data_t d;
        d.surface_type  = st;
        d.x             = 12'(x);
        d.y             = 12'(y);
        d.color         = 24'($urandom);
        d.shadowing_ray = $urandom;
        return d;
    endfunction

    // Scoreboard: every pulse must match the oldest outstanding push, route included.
    always @(negedge clk) begin
        raster_output_data_t e;
        if (!resetn) begin
            prev_any = 1'b0;
        end else begin
            if (bus.shadow_valid || bus.shade_valid) begin
                check("pulse_width", prev_any, 0);
                check("one_route", bus.shadow_valid & bus.shade_valid, 0);
                check("pulse_expected", exp_q.size() != 0, 1);
                pulse_log.push_back(cyc);
                if (bus.shadow_valid) shadow_pulses++;
                else                  shade_pulses++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("route", bus.shadow_valid, e.surface_type != ST_None);
                    check("data", bus.shadow_valid ? bus.shadow_out : bus.shade_out, e);
                end
            end
            prev_any = bus.shadow_valid | bus.shade_valid;
        end
    end

    task automatic push(input raster_output_data_t d);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        bus.valid = 1'b1;
        bus.in    = d;
        exp_q.push_back(d);
        @(posedge clk); #1;
        bus.valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        exp_q.delete();
        shadow_pulses = 0;
        shade_pulses  = 0;
        repeat (cycles) @(posedge clk);
        #1;
        bus.valid = 1'b0;
        resetn    = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(tag, exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_pulse(input bit want_shadow, output int n);
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (want_shadow ? bus.shadow_valid : bus.shade_valid) break;
        end
    endtask

    initial begin
        int n;
        int sp;
        int sh;
        bus.valid            = 1'b1;
        bus.in               = mk(ST_Opaque, 1, 1);
        bus.shadow_fifo_full = 1'b0;
        bus.shade_fifo_full  = 1'b0;

        // 1. reset held with valid asserted
        do_reset(3);
        @(negedge clk);
        check("rst_shadow_valid", bus.shadow_valid, 0);
        check("rst_shade_valid", bus.shade_valid, 0);
        check("rst_fifo_full", bus.output_fifo_full, 0);
        check("rst_count", dut.u_fifo.count, 0);
        repeat (4) @(negedge clk);
        check("rst_no_pulse", shadow_pulses + shade_pulses, 0);

        // 2. single hit
        sh = shade_pulses;
        push(mk(ST_Opaque, 5, 7));
        wait_pulse(1'b1, n);
        check("hit_latency", n, 2);
        check("hit_x", bus.shadow_out.x, 5);
        check("hit_y", bus.shadow_out.y, 7);
        check("hit_no_shade", bus.shade_valid, 0);
        drain("hit_drain");
        check("hit_shade_count", shade_pulses, sh);

        // 3. miss bypass
        sp = shadow_pulses;
        push(mk(ST_None, 9, 3));
        wait_pulse(1'b0, n);
        check("miss_latency", n, 2);
        drain("miss_drain");
        check("miss_no_shadow", shadow_pulses, sp);

        // 4. back-pressure, then ordered release
        bus.shadow_fifo_full = 1'b1;
        sp = shadow_pulses;
        push(mk(ST_Opaque, 10, 1));
        push(mk(ST_Reflective, 11, 2));
        check("bp_full_after2", bus.output_fifo_full, 0);
        push(mk(ST_Refractive, 12, 3));
        check("bp_full_after3", bus.output_fifo_full, 1);
        repeat (5) @(negedge clk);
        check("bp_blocked", shadow_pulses, sp);
        pulse_log.delete();
        @(posedge clk); #1;
        bus.shadow_fifo_full = 1'b0;
        drain("bp_drain");
        check("bp_pulses", pulse_log.size(), 3);
        if (pulse_log.size() == 3) begin
            check("bp_gap0", pulse_log[1] - pulse_log[0], 2);
            check("bp_gap1", pulse_log[2] - pulse_log[1], 2);
        end
        check("bp_full_released", bus.output_fifo_full, 0);

        // 5. blocked hit holds back a following miss
        bus.shadow_fifo_full = 1'b1;
        sh = shade_pulses;
        push(mk(ST_Opaque, 20, 20));
        push(mk(ST_None, 21, 21));
        repeat (8) @(negedge clk);
        check("hb_no_shade", shade_pulses, sh);
        check("hb_count", dut.u_fifo.count, 2);
        @(posedge clk); #1;
        bus.shadow_fifo_full = 1'b0;
        drain("hb_drain");

        // 6. reset with entries queued
        bus.shadow_fifo_full = 1'b1;
        push(mk(ST_Opaque, 30, 1));
        push(mk(ST_Opaque, 31, 2));
        check("mr_count_before", dut.u_fifo.count, 2);
        @(posedge clk); #1;
        do_reset(1);
        bus.shadow_fifo_full = 1'b0;
        repeat (10) @(negedge clk);
        check("mr_no_pulse", shadow_pulses + shade_pulses, 0);
        check("mr_count_after", dut.u_fifo.count, 0);
        check("mr_full_after", bus.output_fifo_full, 0);
        push(mk(ST_Opaque, 40, 41));
        drain("mr_drain");
        check("mr_new_delivered", shadow_pulses, 1);

`ifdef RASTER_DISPATCH_PERF_EN
        check("perf_shadow", perf_shadow_cnt, 32'(shadow_pulses));
        check("perf_bypass", perf_bypass_cnt, 32'(shade_pulses));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
